// File: rtl/fifo_wr_arb_pkg.sv
// ============================================================================
// Module   : fifo_wr_arb_pkg
// Brief    : Width helpers shared by the write-port arbiter (FIFO_WR_ARB_TAG_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_wr_arb_pkg;

    function automatic int tag_bits(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

    // Word presented to the fifo; the source ID rides in the MSBs when tagging.
    function automatic int din_w(input int width, input int n_req);
`ifdef FIFO_WR_ARB_TAG_EN
        return width + tag_bits(n_req);
`else
        return width + 0 * n_req;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arb.vh
// ============================================================================
// Header   : fifo_wr_arb.vh
// Brief    : Sizing macros for the level that instantiates fifo_wr_arb and its
//            fifo; the DIN width follows FIFO_WR_ARB_TAG_EN.
// Revision : 1.0
// ============================================================================
`ifndef FIFO_WR_ARB_VH
`define FIFO_WR_ARB_VH

`define FIFO_WR_ARB_TAG_BITS(n) (((n) < 2) ? 1 : $clog2(n))

`ifdef FIFO_WR_ARB_TAG_EN
`define FIFO_WR_ARB_DIN_W(w, n) ((w) + `FIFO_WR_ARB_TAG_BITS(n))
`else
`define FIFO_WR_ARB_DIN_W(w, n) (w)
`endif

`endif

// File: rtl/fifo_wr_arb_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick: first set request after rr_ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TAG_BITS = 2
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [TAG_BITS-1:0] rr_ptr,
    output logic [TAG_BITS-1:0] winner,
    output logic                any
);

    logic [TAG_BITS-1:0] w_idx;
    logic                w_found;

    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = TAG_BITS'((int'(rr_ptr) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                winner  = w_idx;
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arb.sv
// ============================================================================
// Module   : fifo_wr_arb
// Brief    : Round-robin arbiter sharing one fifo write port between N_REQ
//            requesters; FIFO_WR_ARB_TAG_EN prepends the source ID to fifo_din.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [N_REQ-1:0]                  req,
    input  logic [N_REQ*WIDTH-1:0]            data,
    output logic [N_REQ-1:0]                  gnt,
    input  logic                              flush,
    input  logic                              fifo_full,
    input  logic                              fifo_almost_full,
    output logic                              fifo_w,
    output logic [din_w(WIDTH, N_REQ)-1:0]    fifo_din,
    output logic                              busy
);

    localparam int TAG_BITS = tag_bits(N_REQ);

    logic                r_out_vld;
    logic [WIDTH-1:0]    r_out_data;
    logic [TAG_BITS-1:0] r_rr_ptr;

    logic [TAG_BITS-1:0] w_winner;
    logic                w_any;
    logic                w_accept;
    logic                w_grant;
    logic [WIDTH-1:0]    w_win_data;

    rr_pick #(
        .N_REQ    (N_REQ),
        .TAG_BITS (TAG_BITS)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // A staged word still to be written counts against almost_full, so the
    // fifo can never be written while full.
    assign w_accept = rstn & ~flush & ~fifo_full & ~(r_out_vld & fifo_almost_full);
    assign w_grant  = w_accept & w_any;

    always_comb begin
        gnt        = '0;
        w_win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == TAG_BITS'(i)) begin
                gnt[i]     = w_grant;
                w_win_data = data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_rr_ptr   <= TAG_BITS'(N_REQ - 1);
        end else if (w_grant) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_win_data;
            r_rr_ptr   <= w_winner;
        end else begin
            r_out_vld  <= 1'b0;
        end
    end

`ifdef FIFO_WR_ARB_TAG_EN
    logic [TAG_BITS-1:0] r_out_tag;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_tag <= '0;
        end else if (w_grant) begin
            r_out_tag <= w_winner;
        end
    end

    assign fifo_din = {r_out_tag, r_out_data};
`else
    assign fifo_din = r_out_data;
`endif

    assign fifo_w = r_out_vld;
    assign busy   = r_out_vld | (|req);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
// ============================================================================
// Module   : tb_fifo_wr_arb
// Brief    : Randomized scoreboard bench for fifo_wr_arb with a depth-4 fifo
//            occupancy model; honours FIFO_WR_ARB_TAG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arb;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int TB    = 2;
    localparam int DEPTH = 4;
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int DW = W + TB;
`else
    localparam int DW = W;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  req;
    logic [N*W-1:0] data;
    logic [N-1:0]  gnt;
    logic          flush;
    logic          fifo_full;
    logic          fifo_af;
    logic          fifo_w;
    logic [DW-1:0] fifo_din;
    logic          busy;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .req              (req),
        .data             (data),
        .gnt              (gnt),
        .flush            (flush),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_af),
        .fifo_w           (fifo_w),
        .fifo_din         (fifo_din),
        .busy             (busy)
    );

    // Fifo occupancy model: writes while full are dropped.
    int   fcount = 0;
    logic rd = 1'b0;
    assign fifo_full = (fcount == DEPTH);
    assign fifo_af   = (fcount >= DEPTH - 1);

    always @(posedge clk) begin
        fcount <= fcount + ((fifo_w && fcount < DEPTH) ? 1 : 0) - ((rd && fcount > 0) ? 1 : 0);
    end

    // Requesters must hold req and data until granted.
    for (genvar k = 0; k < N; k++) begin : g_hold
        assert property (@(posedge clk) (req[k] && !gnt[k]) |=> (req[k] && $stable(data[k*W +: W])));
    end

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] sbq[$];
    logic [DW-1:0] mon_exp;

    always @(negedge clk) begin
        if (fifo_w === 1'b1) begin
            n_checks++;
            if (fifo_full) begin
                n_errors++;
                $display("FAIL wr_while_full: fifo_w=1 with fifo_full=%0b, required fifo_full=0", fifo_full);
            end
            n_checks++;
            if (sbq.size() == 0) begin
                n_errors++;
                $display("FAIL din_unexpected: got %h, required no write", fifo_din);
            end else begin
                mon_exp = sbq.pop_front();
                if (fifo_din !== mon_exp) begin
                    n_errors++;
                    $display("FAIL din: got %h, required %h", fifo_din, mon_exp);
                end
            end
        end
    end

    bit           pend [N];
    logic [W-1:0] pdat [N];
    bit           m_vld;
    int           m_last;

    task automatic drive_cycle(input int p_req, input int p_rd, input int p_flush,
                               input bit do_rst, input bit only0);
        bit           acc;
        int           win;
        int           idx;
        logic [N-1:0] egnt;
        logic         ebusy;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && (!only0 || i == 0) && $urandom_range(99) < p_req) begin
                pend[i] = 1'b1;
                pdat[i] = W'($urandom);
            end
            req[i]         = pend[i];
            data[i*W +: W] = pdat[i];
        end
        rd    = ($urandom_range(99) < p_rd);
        flush = ($urandom_range(99) < p_flush);
        rstn  = !do_rst;
        #1;
        acc = rstn && !flush && !fifo_full && !(m_vld && fifo_af);
        win = -1;
        if (acc) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (pend[idx] && win < 0) win = idx;
            end
        end
        egnt  = (win >= 0) ? N'(1 << win) : '0;
        ebusy = m_vld || (req != '0);
        n_checks++;
        if (gnt !== egnt) begin
            n_errors++;
            $display("FAIL gnt: got %b, required %b", gnt, egnt);
        end
        n_checks++;
        if (busy !== ebusy) begin
            n_errors++;
            $display("FAIL busy: got %b, required %b", busy, ebusy);
        end
        n_checks++;
        if (fifo_w !== m_vld) begin
            n_errors++;
            $display("FAIL fifo_w: got %b, required %b", fifo_w, m_vld);
        end
        @(posedge clk);
        if (!rstn) begin
            m_vld  = 1'b0;
            m_last = N - 1;
        end else if (win >= 0) begin
`ifdef FIFO_WR_ARB_TAG_EN
            sbq.push_back({TB'(win), pdat[win]});
`else
            sbq.push_back(pdat[win]);
`endif
            m_vld     = 1'b1;
            m_last    = win;
            pend[win] = 1'b0;
        end else begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        rstn  = 1'b0;
        req   = '0;
        data  = '0;
        flush = 1'b0;
        m_vld = 1'b0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pdat[i] = '0;
        end

        drive_cycle(0, 0, 0, 1'b1, 1'b0);
        drive_cycle(0, 0, 0, 1'b1, 1'b0);

        pend[1] = 1'b1;
        pdat[1] = 8'h5A;
        drive_cycle(0, 0, 0, 1'b0, 1'b0);
        drive_cycle(0, 100, 0, 1'b0, 1'b0);

        pend[3] = 1'b1;
        pdat[3] = 8'hA5;
        drive_cycle(0, 100, 0, 1'b0, 1'b0);
        drive_cycle(0, 100, 0, 1'b0, 1'b0);

        for (int c = 0; c < 2000; c++) begin
            case (c / 400)
                0:       drive_cycle(50, 50, 0, 1'b0, 1'b0);
                1:       drive_cycle(100, 100, 0, 1'b0, 1'b0);
                2:       drive_cycle(100, 0, 0, 1'b0, 1'b1);
                3:       drive_cycle(60, 60, 10, ($urandom_range(99) < 3), 1'b0);
                default: drive_cycle(70, 25, 2, 1'b0, 1'b0);
            endcase
        end

        for (int c = 0; c < 40; c++) begin
            drive_cycle(0, 100, 0, 1'b0, 1'b0);
        end

        n_checks++;
        if (sbq.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d words never written, required 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
